sap_control_sequencer: RTL

Parametrised SAP-class control sequencer: a one-hot T-state ring counter plus instruction decoder driving the 12-bit SAP-1 control word, with configurable ring length, early instruction termination, single-step enable and halt latching. Sits between the instruction register (opcode nibble) and the datapath (PC, MAR, RAM, IR, A, ALU, B, OUT). Drop-in replacement for the fixed 6-state SAP-1 control matrix.

---
 rtl/sap_control_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer
//   SAP-class control sequencer. A one-hot T-state ring counter plus an
//   opcode decoder produce the 12-bit SAP-1 control word for the datapath.
//
// Parameters
//   T_STATES    ring length (6..8); states past T6 only ever emit the idle word
//   SHORT_CYCLE 1 = restart at T1 right after an instruction's last active state
//               0 = always run the full ring
//
// Ports
//   Clk      rising-edge clock (inverted relative to the datapath clock)
//   Clr      synchronous active-high reset; overrides EN and halt
//   EN       advance enable; low holds the ring and the halt flag
//   OPCODE   IR upper nibble; must be valid from T4 to the end of the instruction
//   CONTROL  {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo}
//   LP       load-PC strobe for JMP
//   HLT      registered halted flag
//   T_STATE  one-hot ring, bit0 = T1
//
// Build option
//   SAP_JUMP_EN  when defined, opcode 0x3 is JMP (T4: Ei with LP); otherwise
//                0x3 is a NOP and LP is tied low.

module sap_control_sequencer #(
    parameter int T_STATES    = 6,
    parameter int SHORT_CYCLE = 1
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                EN,
    input  logic [3:0]          OPCODE,
    output logic [11:0]         CONTROL,
    output logic                LP,
    output logic                HLT,
    output logic [T_STATES-1:0] T_STATE
);

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_JMP = 4'h3,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam logic [T_STATES-1:0] RING_T1 = T_STATES'(1);

    localparam logic [11:0] CW_IDLE  = 12'h3E3;
    localparam logic [11:0] CW_T1    = 12'h5E3;
    localparam logic [11:0] CW_T2    = 12'hBE3;
    localparam logic [11:0] CW_T3    = 12'h263;
    localparam logic [11:0] CW_LDMAR = 12'h1A3;
    localparam logic [11:0] CW_LDA5  = 12'h2C3;
    localparam logic [11:0] CW_LDB   = 12'h2E1;
    localparam logic [11:0] CW_ADD6  = 12'h3C7;
    localparam logic [11:0] CW_SUB6  = 12'h3CF;
    localparam logic [11:0] CW_OUT4  = 12'h3F2;
    localparam logic [11:0] CW_JMP4  = 12'h3A3;

    logic [T_STATES-1:0] t_state_q, t_state_d;
    logic                hlt_q, hlt_d;
    logic                ring_legal;
    logic                last_state;
    opcode_e             op;

    assign op         = opcode_e'(OPCODE);
    assign ring_legal = $onehot(t_state_q);

    // Last active T-state of the current instruction; unlisted opcodes are NOPs
    // that end after fetch.
    always_comb begin
        last_state = t_state_q[2];
        case (op)
            OP_LDA:         last_state = t_state_q[4];
            OP_ADD, OP_SUB: last_state = t_state_q[5];
            OP_OUT:         last_state = t_state_q[3];
`ifdef SAP_JUMP_EN
            OP_JMP:         last_state = t_state_q[3];
`endif
            OP_HLT:         last_state = 1'b0;
            default:        last_state = t_state_q[2];
        endcase
    end

    always_comb begin
        t_state_d = t_state_q;
        hlt_d     = hlt_q;
        if (EN && !hlt_q) begin
            if (!ring_legal) begin
                t_state_d = RING_T1;
            end else if (t_state_q[3] && (op == OP_HLT)) begin
                // Halt latches with the ring parked on T4.
                hlt_d = 1'b1;
            end else if (((SHORT_CYCLE != 0) && last_state) || t_state_q[T_STATES-1]) begin
                t_state_d = RING_T1;
            end else begin
                t_state_d = t_state_q << 1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            t_state_q <= RING_T1;
            hlt_q     <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            hlt_q     <= hlt_d;
        end
    end

    always_comb begin
        CONTROL = CW_IDLE;
        LP      = 1'b0;
        if (ring_legal) begin
            if (t_state_q[0]) begin
                CONTROL = CW_T1;
            end else if (t_state_q[1]) begin
                CONTROL = CW_T2;
            end else if (t_state_q[2]) begin
                CONTROL = CW_T3;
            end else if (t_state_q[3]) begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: CONTROL = CW_LDMAR;
                    OP_OUT:                 CONTROL = CW_OUT4;
`ifdef SAP_JUMP_EN
                    OP_JMP: begin
                        CONTROL = CW_JMP4;
                        LP      = 1'b1;
                    end
`endif
                    default:                CONTROL = CW_IDLE;
                endcase
            end else if (t_state_q[4]) begin
                case (op)
                    OP_LDA:         CONTROL = CW_LDA5;
                    OP_ADD, OP_SUB: CONTROL = CW_LDB;
                    default:        CONTROL = CW_IDLE;
                endcase
            end else if (t_state_q[5]) begin
                case (op)
                    OP_ADD:  CONTROL = CW_ADD6;
                    OP_SUB:  CONTROL = CW_SUB6;
                    default: CONTROL = CW_IDLE;
                endcase
            end
        end
    end

    assign T_STATE = t_state_q;
    assign HLT     = hlt_q;

endmodule
